// File: rtl/fp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fp_pkg - widths, constants and scheduler states shared by the fp adder arbiter.
// Revision: 1.0
// ----------------------------------------------------------------------------
package fp_pkg;

    localparam int              FP_W    = 32;
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/fp_add_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fp_add_arbiter_if - requester handshakes plus the start/done link to the adder.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface fp_add_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import fp_pkg::*;

    logic [NUM_REQ-1:0]      req_valid;
    logic [FP_W*NUM_REQ-1:0] req_a;
    logic [FP_W*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      resp_valid;
    logic [FP_W-1:0]         resp_data;
    logic                    resp_err;
    logic [NUM_REQ-1:0]      resp_ready;
    logic                    add_start;
    logic [FP_W-1:0]         add_a;
    logic [FP_W-1:0]         add_b;
    logic                    add_done;
    logic [FP_W-1:0]         add_sum;

    // master: the arbiter; slave: the requesters and adder surrounding it
    modport master (
        input  req_valid, req_a, req_b, resp_ready, add_done, add_sum,
        output req_ready, resp_valid, resp_data, resp_err, add_start, add_a, add_b
    );

    modport slave (
        output req_valid, req_a, req_b, resp_ready, add_done, add_sum,
        input  req_ready, resp_valid, resp_data, resp_err, add_start, add_a, add_b
    );

endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_pick - combinational round-robin pick: first set request at or above ptr, wrapping.
// Revision: 1.0
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o
);
    localparam int SUM_W = IDX_W + 1;

    always_comb begin
        logic [SUM_W-1:0] pos;
        logic             found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // ptr + k is below 2*NUM_REQ, so one conditional subtract is the modulo
            pos = {1'b0, ptr_i} + SUM_W'(k);
            if (pos >= SUM_W'(NUM_REQ)) begin
                pos = pos - SUM_W'(NUM_REQ);
            end
            if (!found && req_i[pos[IDX_W-1:0]]) begin
                found                    = 1'b1;
                grant_o[pos[IDX_W-1:0]] = 1'b1;
                idx_o                    = pos[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fp_add_arbiter - round-robin sharing of one multi-cycle fp adder, with timeout recovery.
// Revision: 1.0
// ----------------------------------------------------------------------------
module fp_add_arbiter
    import fp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    fp_add_arbiter_if.master bus
);
    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FP_W-1:0]    add_a_q, add_a_d;
    logic [FP_W-1:0]    add_b_q, add_b_d;
    logic               add_start_q, add_start_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [FP_W-1:0]    resp_data_q, resp_data_d;
    logic               resp_err_q, resp_err_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    // Nothing is offered while reset is held, even though the state already reads IDLE.
    assign bus.req_ready  = (state_q == IDLE && !reset) ? pick_grant : '0;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.add_start  = add_start_q;
    assign bus.add_a      = add_a_q;
    assign bus.add_b      = add_b_q;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gidx_d       = gidx_q;
        cnt_d        = cnt_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        add_start_d  = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (|pick_grant) begin
                    add_a_d     = bus.req_a[pick_idx*FP_W +: FP_W];
                    add_b_d     = bus.req_b[pick_idx*FP_W +: FP_W];
                    gidx_d      = pick_idx;
                    add_start_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // a done arriving on the final counted cycle still wins over the timeout
                if (bus.add_done) begin
                    resp_data_d          = bus.add_sum;
                    resp_err_d           = 1'b0;
                    resp_valid_d         = '0;
                    resp_valid_d[gidx_q] = 1'b1;
                    state_d              = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    resp_data_d          = FP_QNAN;
                    resp_err_d           = 1'b1;
                    resp_valid_d         = '0;
                    resp_valid_d[gidx_q] = 1'b1;
                    state_d              = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready[gidx_q]) begin
                    resp_valid_d = '0;
                    rr_ptr_d     = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            gidx_q       <= '0;
            cnt_q        <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_start_q  <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gidx_q       <= gidx_d;
            cnt_q        <= cnt_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            add_start_q  <= add_start_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fp_add_arbiter - scenario tasks plus randomized traffic against a round-robin model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_fp_add_arbiter;
    localparam int N   = 4;
    localparam int TMO = 15;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fp_add_arbiter_if #(.NUM_REQ(N)) bus ();

    fp_add_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int model_ptr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scripted adder: exact sums for the named vectors, a fixed scramble otherwise.
    function automatic logic [31:0] fake_sum(logic [31:0] a, logic [31:0] b);
        if (a == 32'h4200_0000 && b == 32'hC120_0000) return 32'h41B0_0000;
        if (a == 32'h40A0_0000 && b == 32'h4200_0000) return 32'h4214_0000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h1;
    endfunction

    function automatic int exp_grant(logic [N-1:0] v, int ptr);
        for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic int onehot_idx(logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    int          add_lat   = 3;
    bit          add_mute  = 1'b0;
    bit          kick      = 1'b0;
    int          pend      = 0;
    int          start_cyc = -1;
    logic [31:0] pa = '0, pb = '0;

    always @(negedge clk) begin
        bus.add_done = 1'b0;
        if (reset) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0 && !add_mute) begin
                    bus.add_done = 1'b1;
                    bus.add_sum  = fake_sum(pa, pb);
                end
            end
            if (kick) begin
                bus.add_done = 1'b1;
                bus.add_sum  = 32'hDEAD_BEEF;
                kick         = 1'b0;
            end
            if (bus.add_start) begin
                pend      = add_lat;
                pa        = bus.add_a;
                pb        = bus.add_b;
                start_cyc = cyc;
            end
        end
    end

    // Stimulus only: waits for an accept, then a response, holds it, then consumes it.
    task automatic serve(input int lat, input int hold, output int g, output int ta,
                         output int tr, output logic [31:0] d, output logic e,
                         output logic [N-1:0] rv, output int glitch);
        g = -1; ta = -1; tr = -1; d = 'x; e = 1'bx; rv = '0; glitch = 0;
        add_lat = lat;
        #1;
        for (int i = 0; i < 40; i++) begin
            if ((bus.req_ready & bus.req_valid) != '0) begin
                g  = onehot_idx(bus.req_ready);
                ta = cyc;
                break;
            end
            @(negedge clk);
        end
        if (g < 0) return;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.resp_valid != '0) begin
                tr = cyc; d = bus.resp_data; e = bus.resp_err; rv = bus.resp_valid;
                break;
            end
        end
        if (tr < 0) return;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.resp_valid !== rv || bus.resp_data !== d || bus.resp_err !== e ||
                bus.add_start !== 1'b0 || bus.req_ready !== '0) glitch++;
        end
        bus.resp_ready = rv;
        @(negedge clk);
        bus.resp_ready = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.req_ready !== '0) begin n_bad++; $display("FAIL reset_req_ready got %h want 0", bus.req_ready); end
        n_cmp++; if (bus.resp_valid !== '0) begin n_bad++; $display("FAIL reset_resp_valid got %h want 0", bus.resp_valid); end
        n_cmp++; if (bus.resp_data !== '0) begin n_bad++; $display("FAIL reset_resp_data got %h want 0", bus.resp_data); end
        n_cmp++; if (bus.resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err got %b want 0", bus.resp_err); end
        n_cmp++; if (bus.add_start !== 1'b0) begin n_bad++; $display("FAIL reset_add_start got %b want 0", bus.add_start); end
        n_cmp++; if (bus.add_a !== '0) begin n_bad++; $display("FAIL reset_add_a got %h want 0", bus.add_a); end
        n_cmp++; if (bus.add_b !== '0) begin n_bad++; $display("FAIL reset_add_b got %h want 0", bus.add_b); end
        reset = 1'b0;
        model_ptr = 0;
    endtask

    task automatic test_single_add();
        int g, ta, tr, gl; logic [31:0] d; logic e; logic [N-1:0] rv;
        bus.req_a[31:0] = 32'h4200_0000;
        bus.req_b[31:0] = 32'hC120_0000;
        bus.req_valid   = 4'b0001;
        serve(3, 0, g, ta, tr, d, e, rv, gl);
        bus.req_valid = '0;
        n_cmp++; if (g !== 0) begin n_bad++; $display("FAIL single_grant got %0d want 0", g); end
        n_cmp++; if (start_cyc !== ta + 1) begin n_bad++; $display("FAIL single_start_cycle got %0d want %0d", start_cyc, ta + 1); end
        n_cmp++; if ({pa, pb} !== {32'h4200_0000, 32'hC120_0000}) begin n_bad++; $display("FAIL single_operands got %h/%h want 42000000/c1200000", pa, pb); end
        n_cmp++; if (tr !== ta + 5) begin n_bad++; $display("FAIL single_resp_cycle got %0d want %0d", tr, ta + 5); end
        n_cmp++; if (d !== 32'h41B0_0000) begin n_bad++; $display("FAIL single_data got %h want 41b00000", d); end
        n_cmp++; if (e !== 1'b0 || rv !== 4'b0001) begin n_bad++; $display("FAIL single_err_valid got %b/%b want 0/0001", e, rv); end
        n_cmp++; if (bus.resp_valid !== '0) begin n_bad++; $display("FAIL single_resp_clear got %b want 0000", bus.resp_valid); end
        model_ptr = 1;
    endtask

    task automatic test_round_robin();
        int g, ta, tr, gl, prev_ta, eg; logic [31:0] d, d2; logic e; logic [N-1:0] rv;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; model_ptr = 0;
        bus.req_a = {$urandom, $urandom, $urandom, $urandom};
        bus.req_b = {$urandom, $urandom, $urandom, $urandom};
        bus.req_a[95:64] = 32'h40A0_0000;
        bus.req_b[95:64] = 32'h4200_0000;
        bus.req_valid = 4'b1111;
        prev_ta = -1; d2 = '0;
        for (int k = 0; k < 5; k++) begin
            eg = exp_grant(bus.req_valid, model_ptr);
            serve(3, 0, g, ta, tr, d, e, rv, gl);
            n_cmp++; if (g !== eg) begin n_bad++; $display("FAIL rr_grant[%0d] got %0d want %0d", k, g, eg); end
            n_cmp++; if (d !== fake_sum(bus.req_a[eg*32 +: 32], bus.req_b[eg*32 +: 32])) begin
                n_bad++; $display("FAIL rr_data[%0d] got %h want %h", k, d, fake_sum(bus.req_a[eg*32 +: 32], bus.req_b[eg*32 +: 32])); end
            if (k > 0) begin
                n_cmp++; if (ta - prev_ta !== 6) begin n_bad++; $display("FAIL rr_throughput[%0d] got %0d want 6", k, ta - prev_ta); end
            end
            if (eg == 2) d2 = d;
            prev_ta = ta;
            model_ptr = (eg + 1) % N;
        end
        n_cmp++; if (d2 !== 32'h4214_0000) begin n_bad++; $display("FAIL rr_req2_sum got %h want 42140000", d2); end
    endtask

    task automatic test_backpressure();
        int g, ta, tr, gl, eg; logic [31:0] d; logic e; logic [N-1:0] rv;
        bus.req_valid = 4'b1111;
        eg = exp_grant(bus.req_valid, model_ptr);
        serve(3, 5, g, ta, tr, d, e, rv, gl);
        bus.req_valid = '0;
        n_cmp++; if (g !== eg || eg !== 1) begin n_bad++; $display("FAIL bp_grant got %0d want 1", g); end
        n_cmp++; if (gl !== 0) begin n_bad++; $display("FAIL bp_hold_stable got %0d bad cycles want 0", gl); end
        n_cmp++; if (rv !== 4'b0010 || d !== fake_sum(bus.req_a[63:32], bus.req_b[63:32])) begin
            n_bad++; $display("FAIL bp_resp got %b/%h want 0010/%h", rv, d, fake_sum(bus.req_a[63:32], bus.req_b[63:32])); end
        model_ptr = (eg + 1) % N;
    endtask

    task automatic test_timeout();
        int g, ta, tr, gl, noise; logic [31:0] d; logic e; logic [N-1:0] rv;
        add_mute = 1'b1;
        bus.req_valid = 4'b0100;
        serve(3, 0, g, ta, tr, d, e, rv, gl);
        bus.req_valid = '0;
        n_cmp++; if (g !== 2) begin n_bad++; $display("FAIL tmo_grant got %0d want 2", g); end
        n_cmp++; if (tr !== ta + 18) begin n_bad++; $display("FAIL tmo_resp_cycle got %0d want %0d", tr, ta + 18); end
        n_cmp++; if (d !== 32'h7FC0_0000) begin n_bad++; $display("FAIL tmo_data got %h want 7fc00000", d); end
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL tmo_err got %b want 1", e); end
        model_ptr = 3;
        kick = 1'b1;
        noise = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.resp_valid !== '0 || bus.add_start !== 1'b0) noise++;
        end
        n_cmp++; if (noise !== 0 || kick !== 1'b0) begin n_bad++; $display("FAIL tmo_late_done got %0d events kick=%b want 0/0", noise, kick); end
        add_mute = 1'b0;
        bus.req_valid = 4'b1000;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b1000) begin n_bad++; $display("FAIL tmo_idle_after got %b want 1000", bus.req_ready); end
        bus.req_valid = '0;
    endtask

    task automatic test_reset_mid_wait();
        int g, g2, ta, tr, gl, eg; logic [31:0] d; logic e; logic [N-1:0] rv;
        bus.req_a = {$urandom | 32'h1, $urandom, $urandom, $urandom};
        bus.req_b = {$urandom | 32'h1, $urandom, $urandom, $urandom};
        bus.req_valid = 4'b1100;
        eg = exp_grant(bus.req_valid, model_ptr);
        add_lat = 10;
        g = -1;
        #1;
        for (int i = 0; i < 10; i++) begin
            if ((bus.req_ready & bus.req_valid) != '0) begin g = onehot_idx(bus.req_ready); break; end
            @(negedge clk);
        end
        n_cmp++; if (g !== eg || eg !== 3) begin n_bad++; $display("FAIL rst_first_grant got %0d want 3", g); end
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({bus.req_ready, bus.resp_valid, bus.resp_data, bus.resp_err, bus.add_start, bus.add_a, bus.add_b} !== '0) begin
            n_bad++; $display("FAIL rst_outputs got rr=%b rv=%b rd=%h re=%b as=%b a=%h b=%h want all 0",
                bus.req_ready, bus.resp_valid, bus.resp_data, bus.resp_err, bus.add_start, bus.add_a, bus.add_b); end
        @(negedge clk);
        reset = 1'b0;
        model_ptr = 0;
        eg = exp_grant(bus.req_valid, model_ptr);
        serve(3, 0, g2, ta, tr, d, e, rv, gl);
        bus.req_valid = '0;
        n_cmp++; if (g2 !== eg || eg !== 2) begin n_bad++; $display("FAIL rst_next_grant got %0d want 2", g2); end
        n_cmp++; if (rv !== 4'b0100) begin n_bad++; $display("FAIL rst_stale_resp got %b want 0100", rv); end
        n_cmp++; if (d !== fake_sum(bus.req_a[95:64], bus.req_b[95:64]) || e !== 1'b0) begin
            n_bad++; $display("FAIL rst_next_data got %h/%b want %h/0", d, e, fake_sum(bus.req_a[95:64], bus.req_b[95:64])); end
        model_ptr = 3;
    endtask

    task automatic test_wrap_around();
        int g, ta, tr, gl, eg; logic [31:0] d; logic e; logic [N-1:0] rv;
        bus.req_valid = 4'b1010;
        for (int k = 0; k < 2; k++) begin
            eg = exp_grant(bus.req_valid, model_ptr);
            serve(3, 0, g, ta, tr, d, e, rv, gl);
            n_cmp++; if (g !== eg || eg !== (k == 0 ? 3 : 1)) begin n_bad++; $display("FAIL wrap_grant[%0d] got %0d want %0d", k, g, (k == 0 ? 3 : 1)); end
            n_cmp++; if (d !== fake_sum(bus.req_a[eg*32 +: 32], bus.req_b[eg*32 +: 32])) begin
                n_bad++; $display("FAIL wrap_data[%0d] got %h want %h", k, d, fake_sum(bus.req_a[eg*32 +: 32], bus.req_b[eg*32 +: 32])); end
            model_ptr = (eg + 1) % N;
        end
        bus.req_valid = '0;
    endtask

    task automatic test_random();
        int g, ta, tr, gl, eg, lat, hold; logic [31:0] d, ed; logic e; logic [N-1:0] rv, v;
        for (int it = 0; it < 24; it++) begin
            v    = N'($urandom_range(1, 15));
            lat  = $urandom_range(1, 8);
            hold = $urandom_range(0, 3);
            bus.req_a = {$urandom, $urandom, $urandom, $urandom};
            bus.req_b = {$urandom, $urandom, $urandom, $urandom};
            eg = exp_grant(v, model_ptr);
            ed = fake_sum(bus.req_a[eg*32 +: 32], bus.req_b[eg*32 +: 32]);
            bus.req_valid = v;
            serve(lat, hold, g, ta, tr, d, e, rv, gl);
            n_cmp++; if (g !== eg) begin n_bad++; $display("FAIL rnd_grant[%0d] got %0d want %0d", it, g, eg); end
            n_cmp++; if (d !== ed || e !== 1'b0) begin n_bad++; $display("FAIL rnd_data[%0d] got %h/%b want %h/0", it, d, e, ed); end
            n_cmp++; if (tr - ta !== lat + 2) begin n_bad++; $display("FAIL rnd_latency[%0d] got %0d want %0d", it, tr - ta, lat + 2); end
            n_cmp++; if (gl !== 0 || rv !== N'(1 << eg)) begin n_bad++; $display("FAIL rnd_resp[%0d] got %b glitch=%0d want %b glitch=0", it, rv, gl, N'(1 << eg)); end
            model_ptr = (eg + 1) % N;
        end
        bus.req_valid = '0;
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = '0;
        bus.add_done   = 1'b0;
        bus.add_sum    = '0;
        test_reset();
        test_single_add();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid_wait();
        test_wrap_around();
        test_random();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Round-robin scheduler that shares one multi-cycle single-precision floating-point adder among `NUM_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues one add at a time to the adder via a start/done interface. It returns each sum to the requester that issued it. If the adder fails to answer in time, the block recovers and returns an error result. It sits between the datapath clients and the shared adder unit.

## Interface
- `NUM_REQ`, 4: number of requesters; range 2..8.
- `TIMEOUT`, 15: maximum number of cycles to wait in WAIT for `add_done` before aborting.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  NUM_REQ  requester i has an operand pair pending.
- `req_a`, `req_b`  in  32*NUM_REQ  IEEE-754 operands; requester i occupies bits [32i+31:32i].
- `req_ready`  out  NUM_REQ  one-hot accept strobe.
- `resp_valid`  out  NUM_REQ  one-hot; result present for requester i.
- `resp_data`  out  32  sum, shared by all requesters.
- `resp_err`  out  1  qualifies `resp_data` as a timeout result.
- `resp_ready`  in  NUM_REQ  requester i consumes its result.
- `add_start`  out  1  one-cycle pulse to the adder.
- `add_a`, `add_b`  out  32  operands held stable from `add_start` until `add_done` or timeout.
- `add_done`  in  1  adder result valid; one-cycle pulse.
- `add_sum`  in  32  adder result.

## Operation
The block is a four-state FSM: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - Grant `g` goes to the first requester with `req_valid` set, searching upward from `rr_ptr` and wrapping modulo `NUM_REQ`.
  - `req_ready[g]` is combinational and high only in IDLE, only for `g`.
  - On handshake (`req_valid[g] & req_ready[g]`): latch `req_a[g]` and `req_b[g]` into `add_a`/`add_b`, latch `g`, then go to ISSUE.
  - No valid requester: stay in IDLE.
- **ISSUE**
  - Assert `add_start` for exactly one cycle.
  - Clear the timeout counter and go to WAIT.
- **WAIT**
  - On `add_done`: latch `add_sum` into `resp_data`, set `resp_err=0`, go to RESP.
  - Otherwise increment the counter.
  - When the counter reaches `TIMEOUT` with no `add_done`: set `resp_data=32'h7FC00000` (quiet NaN), set `resp_err=1`, go to RESP.
- **RESP**
  - Hold `resp_valid[g]=1` with `resp_data` and `resp_err` stable until `resp_ready[g]`.
  - On that cycle: set `rr_ptr=(g+1) mod NUM_REQ` and go to IDLE.
- **Ignored inputs**
  - `add_done` outside WAIT is ignored. This covers a late pulse after a timeout.
  - `resp_ready` bits other than `resp_ready[g]` are ignored.
- **Fairness**
  - Only one transaction is in flight.
  - Between two grants to the same requester, every other continuously-valid requester is granted exactly once.
- **Reset**
  - Applies at any time, including mid-transaction, and aborts the transaction.
  - State=IDLE and `rr_ptr=0`.
  - All outputs are 0: `req_ready`, `resp_valid`, `resp_data`, `resp_err`, `add_start`, `add_a`, `add_b`.
  - The requester whose transaction was aborted receives no response.

## Timing
- Accept at cycle T (IDLE) → `add_start` at T+1 → WAIT from T+2.
- `add_done` sampled at cycle D → `resp_valid` high from D+1.
- Zero-wait consumer: `resp_ready` at D+1 → IDLE at D+2 → next accept possible at D+2.
- Throughput with an adder of latency L (done at T+1+L): one add per L+3 cycles.
- Timeout: `resp_valid` rises at T+3+TIMEOUT if `add_done` never arrives.
- `resp_valid` and `add_start` are registered. `req_ready` is combinational from state, `rr_ptr` and `req_valid`.

## Structure
- Package `fp_pkg`:
  - `FP_W=32`
  - `FP_QNAN=32'h7FC00000`
  - state enum `{IDLE, ISSUE, WAIT, RESP}`
- Sub-module `rr_pick`: combinational, takes `NUM_REQ`-wide `req` and `ptr`, produces one-hot `grant` and binary `idx`. It is reused by later arbiters.

## Test plan
- **Single add:** requester 0 sends `a=0x42000000`, `b=0xC1200000`; the adder model (L=3) returns `0x41B00000` → `resp_valid[0]` with `resp_data=0x41B00000`, `resp_err=0`, at D+1.
- **Round-robin:** all four requesters valid continuously from reset → grants in order 0,1,2,3,0. Requester 2 sending `0x40A00000+0x42000000` gets `0x42140000`.
- **Response backpressure:** hold `resp_ready[1]=0` for 5 cycles → `resp_valid[1]` and `resp_data` stay stable; no `add_start` and no `req_ready` in that window.
- **Timeout:** the adder never asserts `add_done` → `resp_valid` at T+18 with `resp_data=0x7FC00000`, `resp_err=1`. A late `add_done` in IDLE changes nothing.
- **Reset mid-WAIT:** pulse `reset` → all outputs 0 immediately, `rr_ptr=0`, the next grant goes to the lowest valid requester, and no stale response appears.
- **Wrap-around:** `rr_ptr=3`, only requesters 1 and 3 valid → grant 3, then 1.
